// File: rtl/tl_pkg.sv
// TileLink-UL channel payload types shared by the register-bridge arbiter slice.
package tl_pkg;

   localparam int unsigned TL_AW   = 32;
   localparam int unsigned TL_DW   = 32;
   localparam int unsigned TL_SRCW = 8;
   localparam int unsigned TL_SZW  = 2;
   localparam int unsigned TL_MW   = TL_DW / 8;

   typedef enum logic [2:0] {
      PutFullData    = 3'd0,
      PutPartialData = 3'd1,
      ArithmeticData = 3'd2,
      LogicalData    = 3'd3,
      Get            = 3'd4,
      Intent         = 3'd5
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'd0,
      AccessAckData = 3'd1,
      HintAck       = 3'd2
   } tl_d_op_e;

   typedef struct packed {
      tl_a_op_e            opcode;
      logic [2:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [TL_AW-1:0]    address;
      logic [TL_MW-1:0]    mask;
      logic [TL_DW-1:0]    data;
   } A_chan_bits_t;

   typedef struct packed {
      tl_d_op_e            opcode;
      logic [1:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [0:0]          sink;
      logic                denied;
      logic [TL_DW-1:0]    data;
      logic                corrupt;
   } D_chan_bits_t;

   // Width of an index able to address n requesters (never narrower than 1 bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tl_reg_arbiter_if.sv
// Signal bundle between NUM_REQ TileLink requesters, the arbiter and the register bridge.
interface tl_reg_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   import tl_pkg::*;

   // Requester side
   logic [NUM_REQ-1:0] req_A_valid_i;
   logic [NUM_REQ-1:0] req_A_ready_o;
   A_chan_bits_t       req_A_bits_i [NUM_REQ];
   logic [NUM_REQ-1:0] req_D_valid_o;
   logic [NUM_REQ-1:0] req_D_ready_i;
   D_chan_bits_t       req_D_bits_o [NUM_REQ];

   // Bridge side
   logic               TL_A_valid_o;
   logic               TL_A_ready_i;
   A_chan_bits_t       TL_A_bits_o;
   logic               TL_D_valid_i;
   logic               TL_D_ready_o;
   D_chan_bits_t       TL_D_bits_i;

   // Arbiter view
   modport slave (
      input  req_A_valid_i, req_A_bits_i, req_D_ready_i,
      input  TL_A_ready_i, TL_D_valid_i, TL_D_bits_i,
      output req_A_ready_o, req_D_valid_o, req_D_bits_o,
      output TL_A_valid_o, TL_A_bits_o, TL_D_ready_o
   );

   // Environment view (requesters plus bridge)
   modport master (
      output req_A_valid_i, req_A_bits_i, req_D_ready_i,
      output TL_A_ready_i, TL_D_valid_i, TL_D_bits_i,
      input  req_A_ready_o, req_D_valid_o, req_D_bits_o,
      input  TL_A_valid_o, TL_A_bits_o, TL_D_ready_o
   );

endinterface

// File: rtl/tl_reg_arbiter_rr_arb_sel.sv
// Combinational round-robin selector: first set request at or above i_ptr, wrapping modulo N.
module rr_arb_sel #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   int unsigned w_pos;

   // Scan from the pointer upward; the first hit wins and later hits are ignored.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      w_pos = 0;
      for (int unsigned off = 0; off < N; off++) begin
         w_pos = 32'(i_ptr) + off;
         if (w_pos >= N) begin
            w_pos = w_pos - N;
         end
         if (!o_any && i_req[IDX_W'(w_pos)]) begin
            o_any = 1'b1;
            o_idx = IDX_W'(w_pos);
         end
      end
   end

endmodule

// File: rtl/tl_reg_arbiter.sv
// Round-robin arbiter sharing one TileLink-to-register bridge among NUM_REQ requesters,
// one transaction in flight, D response steered back to the granted requester.
module tl_reg_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   tl_reg_arbiter_if.slave bus
);
   import tl_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_WAIT_D
   } state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   w_grant_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   w_rr_ptr_nxt;
   logic [IDX_W-1:0]   w_ptr_inc;
   logic [IDX_W-1:0]   w_win;
   logic               w_any;

   logic               w_a_valid;
   A_chan_bits_t       w_a_bits;
   logic [NUM_REQ-1:0] w_a_ready;
   logic [NUM_REQ-1:0] w_d_valid;
   logic               w_d_ready;

   rr_arb_sel #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_sel (
      .i_req (bus.req_A_valid_i),
      .i_ptr (r_rr_ptr),
      .o_idx (w_win),
      .o_any (w_any)
   );

   // Pointer moves to the requester after the one just served; stays 0 when NUM_REQ is 1.
   assign w_ptr_inc = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
      end
   end

   // Next-state and channel steering; HOLD freezes arbitration on the registered grant.
   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_ptr_nxt = r_rr_ptr;
      w_a_valid    = 1'b0;
      w_a_bits     = '0;
      w_a_ready    = '0;
      w_d_valid    = '0;
      w_d_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_a_valid        = 1'b1;
               w_a_bits         = bus.req_A_bits_i[w_win];
               w_a_ready[w_win] = bus.TL_A_ready_i;
               w_grant_nxt      = w_win;
               w_state_nxt      = bus.TL_A_ready_i ? ST_WAIT_D : ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_a_valid          = bus.req_A_valid_i[r_grant];
            w_a_bits           = bus.req_A_bits_i[r_grant];
            w_a_ready[r_grant] = bus.TL_A_ready_i;
            if (w_a_valid && bus.TL_A_ready_i) begin
               w_state_nxt = ST_WAIT_D;
            end
         end
         ST_WAIT_D: begin
            w_d_valid[r_grant] = bus.TL_D_valid_i;
            w_d_ready          = bus.req_D_ready_i[r_grant];
            if (bus.TL_D_valid_i && w_d_ready) begin
               w_state_nxt  = ST_IDLE;
               w_rr_ptr_nxt = w_ptr_inc;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // All outputs are forced to zero while reset is held, independent of the clock.
   assign bus.TL_A_valid_o  = w_a_valid & ~rst_i;
   assign bus.TL_A_bits_o   = rst_i ? '0 : w_a_bits;
   assign bus.req_A_ready_o = rst_i ? '0 : w_a_ready;
   assign bus.req_D_valid_o = rst_i ? '0 : w_d_valid;
   assign bus.TL_D_ready_o  = w_d_ready & ~rst_i;

   // D payload is broadcast; only the granted requester sees valid.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         bus.req_D_bits_o[i] = rst_i ? '0 : bus.TL_D_bits_i;
      end
   end

endmodule

// File: tb/tb_tl_reg_arbiter.sv
// Directed bench for tl_reg_arbiter: a 4-requester instance and a single-requester instance.
module tb_tl_reg_arbiter;
   import tl_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk_i = ~clk_i;

   tl_reg_arbiter_if #(.NUM_REQ(4)) bus4 ();
   tl_reg_arbiter_if #(.NUM_REQ(1)) bus1 ();

   tl_reg_arbiter #(.NUM_REQ(4)) u_dut4 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus4)
   );

   tl_reg_arbiter #(.NUM_REQ(1)) u_dut1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus1)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic A_chan_bits_t mk_a(input tl_a_op_e op, input int unsigned src,
                                         input logic [31:0] addr, input logic [31:0] data);
      A_chan_bits_t a;
      a         = '0;
      a.opcode  = op;
      a.size    = 2'd2;
      a.source  = 8'(src);
      a.address = addr;
      a.mask    = 4'hF;
      a.data    = data;
      return a;
   endfunction

   function automatic D_chan_bits_t mk_d(input tl_d_op_e op, input int unsigned src,
                                         input logic [31:0] data);
      D_chan_bits_t d;
      d        = '0;
      d.opcode = op;
      d.size   = 2'd2;
      d.source = 8'(src);
      d.data   = data;
      return d;
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic clear4();
      bus4.req_A_valid_i = '0;
      for (int i = 0; i < 4; i++) bus4.req_A_bits_i[i] = '0;
      bus4.req_D_ready_i = '1;
      bus4.TL_A_ready_i  = 1'b0;
      bus4.TL_D_valid_i  = 1'b0;
      bus4.TL_D_bits_i   = '0;
   endtask

   task automatic clear1();
      bus1.req_A_valid_i   = '0;
      bus1.req_A_bits_i[0] = '0;
      bus1.req_D_ready_i   = '1;
      bus1.TL_A_ready_i    = 1'b0;
      bus1.TL_D_valid_i    = 1'b0;
      bus1.TL_D_bits_i     = '0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
   endtask

   initial begin
      logic [3:0] oh;
      int unsigned exp_order [5];
      exp_order = '{0, 1, 2, 3, 0};

      // Reset with every input active: all outputs must read zero.
      rst_i = 1'b1;
      clear4();
      clear1();
      bus4.req_A_valid_i = '1;
      bus4.TL_A_ready_i  = 1'b1;
      bus4.TL_D_valid_i  = 1'b1;
      bus4.TL_D_bits_i   = mk_d(AccessAckData, 1, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) bus4.req_A_bits_i[i] = mk_a(Get, i, 32'h100 + 32'(i), 0);
      sample();
      check("rst_a_valid", 128'(bus4.TL_A_valid_o), 128'(0));
      check("rst_a_ready", 128'(bus4.req_A_ready_o), 128'(0));
      check("rst_d_valid", 128'(bus4.req_D_valid_o), 128'(0));
      check("rst_d_ready", 128'(bus4.TL_D_ready_o), 128'(0));
      check("rst_a_bits", 128'(bus4.TL_A_bits_o), 128'(0));
      check("rst_d_bits1", 128'(bus4.req_D_bits_o[1]), 128'(0));
      next_cycle();
      clear4();
      rst_i = 1'b0;
      sample();
      check("rst_state", 128'(u_dut4.r_state), 128'(0));
      check("rst_ptr", 128'(u_dut4.r_rr_ptr), 128'(0));
      check("rst_grant", 128'(u_dut4.r_grant), 128'(0));
      next_cycle();

      // Single requester 2: Get to 0x1000, D routed only to requester 2.
      bus4.req_A_valid_i[2] = 1'b1;
      bus4.req_A_bits_i[2]  = mk_a(Get, 2, 32'h1000, 0);
      bus4.TL_A_ready_i     = 1'b1;
      sample();
      check("t1_a_valid", 128'(bus4.TL_A_valid_o), 128'(1));
      check("t1_a_addr", 128'(bus4.TL_A_bits_o.address), 128'(32'h1000));
      check("t1_a_src", 128'(bus4.TL_A_bits_o.source), 128'(2));
      check("t1_a_ready", 128'(bus4.req_A_ready_o), 128'(4'b0100));
      next_cycle();
      bus4.req_A_valid_i[2] = 1'b0;
      bus4.TL_D_valid_i     = 1'b1;
      bus4.TL_D_bits_i      = mk_d(AccessAckData, 2, 32'hCAFE_0001);
      sample();
      check("t1_d_valid", 128'(bus4.req_D_valid_o), 128'(4'b0100));
      check("t1_d_ready", 128'(bus4.TL_D_ready_o), 128'(1));
      check("t1_d_data", 128'(bus4.req_D_bits_o[2].data), 128'(32'hCAFE_0001));
      check("t1_a_quiet", 128'(bus4.TL_A_valid_o), 128'(0));
      next_cycle();
      bus4.TL_D_valid_i = 1'b0;
      sample();
      check("t1_ptr", 128'(u_dut4.r_rr_ptr), 128'(3));
      check("t1_state", 128'(u_dut4.r_state), 128'(0));
      next_cycle();

      // Four requesters continuously valid: grants 0,1,2,3,0.
      clear4();
      do_reset();
      for (int i = 0; i < 4; i++) bus4.req_A_bits_i[i] = mk_a(Get, i, 32'h2000 + 32'(4 * i), 0);
      bus4.req_A_valid_i = '1;
      bus4.TL_A_ready_i  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << exp_order[k];
         bus4.TL_D_valid_i = 1'b0;
         sample();
         check("t2_a_grant", 128'(bus4.req_A_ready_o), 128'(oh));
         check("t2_a_src", 128'(bus4.TL_A_bits_o.source), 128'(exp_order[k]));
         next_cycle();
         bus4.TL_D_valid_i = 1'b1;
         bus4.TL_D_bits_i  = mk_d(AccessAckData, exp_order[k], 32'h100 + exp_order[k]);
         sample();
         check("t2_d_valid", 128'(bus4.req_D_valid_o), 128'(oh));
         check("t2_d_src", 128'(bus4.req_D_bits_o[exp_order[k]].source), 128'(exp_order[k]));
         check("t2_a_blocked", 128'(bus4.req_A_ready_o), 128'(0));
         next_cycle();
      end
      clear4();

      // Bridge stalls A; requester 1 holds the bus while requester 0 arrives.
      bus4.req_A_valid_i[1] = 1'b1;
      bus4.req_A_bits_i[1]  = mk_a(PutFullData, 1, 32'h3000, 32'h1111_1111);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus4.req_A_valid_i[0] = 1'b1;
            bus4.req_A_bits_i[0]  = mk_a(Get, 0, 32'h3004, 0);
         end
         sample();
         check("t3_hold_valid", 128'(bus4.TL_A_valid_o), 128'(1));
         check("t3_hold_addr", 128'(bus4.TL_A_bits_o.address), 128'(32'h3000));
         check("t3_hold_ready", 128'(bus4.req_A_ready_o), 128'(0));
         next_cycle();
      end
      bus4.TL_A_ready_i = 1'b1;
      sample();
      check("t3_accept1", 128'(bus4.req_A_ready_o), 128'(4'b0010));
      check("t3_accept_src", 128'(bus4.TL_A_bits_o.source), 128'(1));
      next_cycle();
      bus4.req_A_valid_i[1] = 1'b0;
      bus4.TL_D_valid_i     = 1'b1;
      bus4.TL_D_bits_i      = mk_d(AccessAck, 1, 0);
      sample();
      check("t3_d1", 128'(bus4.req_D_valid_o), 128'(4'b0010));
      next_cycle();
      bus4.TL_D_valid_i = 1'b0;
      sample();
      check("t3_accept0", 128'(bus4.req_A_ready_o), 128'(4'b0001));
      check("t3_src0", 128'(bus4.TL_A_bits_o.source), 128'(0));
      next_cycle();
      bus4.req_A_valid_i[0] = 1'b0;
      bus4.TL_D_valid_i     = 1'b1;
      bus4.TL_D_bits_i      = mk_d(AccessAckData, 0, 32'h55);
      sample();
      check("t3_d0", 128'(bus4.req_D_valid_o), 128'(4'b0001));
      next_cycle();

      // Requester 3 back-pressures D for four cycles.
      clear4();
      bus4.req_A_valid_i[3] = 1'b1;
      bus4.req_A_bits_i[3]  = mk_a(Get, 3, 32'h4000, 0);
      bus4.TL_A_ready_i     = 1'b1;
      sample();
      check("t4_accept3", 128'(bus4.req_A_ready_o), 128'(4'b1000));
      next_cycle();
      bus4.req_A_valid_i[3] = 1'b0;
      bus4.req_A_valid_i[0] = 1'b1;
      bus4.req_A_bits_i[0]  = mk_a(Get, 0, 32'h4004, 0);
      bus4.req_D_ready_i[3] = 1'b0;
      bus4.TL_D_valid_i     = 1'b1;
      bus4.TL_D_bits_i      = mk_d(AccessAckData, 3, 32'h77);
      for (int c = 1; c <= 4; c++) begin
         sample();
         check("t4_d_ready_lo", 128'(bus4.TL_D_ready_o), 128'(0));
         check("t4_d_valid", 128'(bus4.req_D_valid_o), 128'(4'b1000));
         check("t4_no_a", 128'(bus4.req_A_ready_o), 128'(0));
         check("t4_no_a_valid", 128'(bus4.TL_A_valid_o), 128'(0));
         next_cycle();
      end
      bus4.req_D_ready_i[3] = 1'b1;
      bus4.req_A_valid_i[0] = 1'b0;
      sample();
      check("t4_d_ready_hi", 128'(bus4.TL_D_ready_o), 128'(1));
      next_cycle();
      bus4.TL_D_valid_i = 1'b0;
      sample();
      check("t4_ptr_wrap", 128'(u_dut4.r_rr_ptr), 128'(0));
      check("t4_idle", 128'(u_dut4.r_state), 128'(0));
      next_cycle();

      // Reset during WAIT_D: outputs drop at once, pointer returns to 0.
      clear4();
      bus4.req_A_valid_i[1] = 1'b1;
      bus4.req_A_bits_i[1]  = mk_a(Get, 1, 32'h5000, 0);
      bus4.TL_A_ready_i     = 1'b1;
      sample();
      check("t5_accept1", 128'(bus4.req_A_ready_o), 128'(4'b0010));
      next_cycle();
      bus4.req_A_valid_i[1] = 1'b0;
      bus4.TL_D_valid_i     = 1'b1;
      bus4.TL_D_bits_i      = mk_d(AccessAck, 1, 0);
      next_cycle();
      bus4.TL_D_valid_i     = 1'b0;
      bus4.req_A_valid_i[2] = 1'b1;
      bus4.req_A_bits_i[2]  = mk_a(Get, 2, 32'h5008, 0);
      sample();
      check("t5_accept2", 128'(bus4.req_A_ready_o), 128'(4'b0100));
      next_cycle();
      bus4.req_A_valid_i = '1;
      for (int i = 0; i < 4; i++) bus4.req_A_bits_i[i] = mk_a(Get, i, 32'h6000, 0);
      bus4.TL_D_valid_i = 1'b1;
      bus4.TL_D_bits_i  = mk_d(AccessAckData, 2, 32'h99);
      #1;
      check("t5_pre_d_valid", 128'(bus4.req_D_valid_o), 128'(4'b0100));
      rst_i = 1'b1;
      #1;
      check("t5_rst_d_valid", 128'(bus4.req_D_valid_o), 128'(0));
      check("t5_rst_d_ready", 128'(bus4.TL_D_ready_o), 128'(0));
      check("t5_rst_d_bits", 128'(bus4.req_D_bits_o[2]), 128'(0));
      check("t5_rst_a_valid", 128'(bus4.TL_A_valid_o), 128'(0));
      check("t5_rst_a_ready", 128'(bus4.req_A_ready_o), 128'(0));
      next_cycle();
      rst_i = 1'b0;
      bus4.TL_D_valid_i = 1'b0;
      sample();
      check("t5_state", 128'(u_dut4.r_state), 128'(0));
      check("t5_ptr", 128'(u_dut4.r_rr_ptr), 128'(0));
      check("t5_win0", 128'(bus4.req_A_ready_o), 128'(4'b0001));
      next_cycle();
      bus4.req_A_valid_i = '0;
      bus4.TL_D_valid_i  = 1'b1;
      bus4.TL_D_bits_i   = mk_d(AccessAckData, 0, 32'h1);
      sample();
      check("t5_d0", 128'(bus4.req_D_valid_o), 128'(4'b0001));
      next_cycle();
      clear4();

      // Single-requester build: PutFullData then Get back to back.
      bus1.req_A_valid_i   = 1'b1;
      bus1.req_A_bits_i[0] = mk_a(PutFullData, 0, 32'h10, 32'hA5A5_A5A5);
      bus1.TL_A_ready_i    = 1'b1;
      sample();
      check("t6_put_ready", 128'(bus1.req_A_ready_o), 128'(1));
      check("t6_put_op", 128'(bus1.TL_A_bits_o.opcode), 128'(PutFullData));
      next_cycle();
      bus1.req_A_bits_i[0] = mk_a(Get, 0, 32'h10, 0);
      bus1.TL_D_valid_i    = 1'b1;
      bus1.TL_D_bits_i     = mk_d(AccessAck, 0, 0);
      sample();
      check("t6_ack_valid", 128'(bus1.req_D_valid_o), 128'(1));
      check("t6_ack_op", 128'(bus1.req_D_bits_o[0].opcode), 128'(AccessAck));
      check("t6_get_wait", 128'(bus1.req_A_ready_o), 128'(0));
      next_cycle();
      bus1.TL_D_valid_i = 1'b0;
      sample();
      check("t6_get_ready", 128'(bus1.req_A_ready_o), 128'(1));
      check("t6_get_op", 128'(bus1.TL_A_bits_o.opcode), 128'(Get));
      next_cycle();
      bus1.req_A_valid_i = 1'b0;
      bus1.TL_D_valid_i  = 1'b1;
      bus1.TL_D_bits_i   = mk_d(AccessAckData, 0, 32'hA5A5_A5A5);
      sample();
      check("t6_data_valid", 128'(bus1.req_D_valid_o), 128'(1));
      check("t6_data_op", 128'(bus1.req_D_bits_o[0].opcode), 128'(AccessAckData));
      check("t6_data", 128'(bus1.req_D_bits_o[0].data), 128'(32'hA5A5_A5A5));
      next_cycle();
      bus1.TL_D_valid_i = 1'b0;
      sample();
      check("t6_ptr", 128'(u_dut1.r_rr_ptr), 128'(0));
      check("t6_idle", 128'(u_dut1.r_state), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tl_reg_arbiter.md
# tl_reg_arbiter

Round-robin TileLink arbiter that shares one TileLink-to-register bridge among `NUM_REQ` TileLink masters. The block sits between the requesters (core MMIO port, debug module, DMA) and the bridge's A/D channel pair. It allows exactly one transaction in flight and routes each D response back to the requester that issued the matching A beat.

## Interface
Parameters:
- `NUM_REQ`, 4: number of upstream requesters (≥1).
- `IDX_W`, `NUM_REQ>1 ? $clog2(NUM_REQ) : 1`: grant index width (derived; do not override).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_A_valid_i` in [NUM_REQ]: per-requester A valid.
- `req_A_ready_o` out [NUM_REQ]: per-requester A ready.
- `req_A_bits_i` in `tl_pkg::A_chan_bits_t` [NUM_REQ]: per-requester A payload.
- `req_D_valid_o` out [NUM_REQ]: per-requester D valid.
- `req_D_ready_i` in [NUM_REQ]: per-requester D ready.
- `req_D_bits_o` out `tl_pkg::D_chan_bits_t` [NUM_REQ]: D payload, same value broadcast to all requesters.
- `TL_A_valid_o` out 1: A valid to bridge.
- `TL_A_ready_i` in 1: A ready from bridge.
- `TL_A_bits_o` out `tl_pkg::A_chan_bits_t`: A payload to bridge.
- `TL_D_valid_i` in 1: D valid from bridge.
- `TL_D_ready_o` out 1: D ready to bridge.
- `TL_D_bits_i` in `tl_pkg::D_chan_bits_t`: D payload from bridge.

## Operation
- Registers:
  - `state_q`: IDLE, HOLD or WAIT_D.
  - `grant_q` [IDX_W]: index of the granted requester.
  - `rr_ptr_q` [IDX_W]: requester with top priority in the next arbitration.
- Winner selection: the first requester with valid asserted, searching from `rr_ptr_q` upward and wrapping modulo `NUM_REQ`. The selection is combinational.
- IDLE:
  - If any `req_A_valid_i` is set: drive `TL_A_valid_o`=1 and `TL_A_bits_o`=bits of the winner, and set `req_A_ready_o[winner]`=`TL_A_ready_i`.
  - On handshake: `grant_q`←winner, go to WAIT_D.
  - If valid but no ready: `grant_q`←winner, go to HOLD.
- HOLD:
  - Forward requester `grant_q` only. Arbitration is frozen, so the presented beat never changes before it is accepted.
  - On handshake, go to WAIT_D.
- WAIT_D:
  - `TL_A_valid_o`=0 and every `req_A_ready_o`=0.
  - `req_D_valid_o[grant_q]`=`TL_D_valid_i`; all other D valids are 0. `TL_D_ready_o`=`req_D_ready_i[grant_q]`.
  - On D handshake: go to IDLE, `rr_ptr_q`←(`grant_q`+1) mod `NUM_REQ`.
- `TL_D_ready_o`=0 outside WAIT_D. A D valid from the bridge in IDLE or HOLD is a protocol error and is not forwarded.
- `rr_ptr_q` advances only on D completion, never on A acceptance.
- Requesters must hold valid and bits stable until accepted (TileLink rule). A requester that drops valid in HOLD breaks that rule; the block does not need to handle it.
- `NUM_REQ`=1: the arbiter reduces to a single-outstanding pass-through, and the pointer stays 0.

## Timing
- Reset values: state=IDLE, `grant_q`=0, `rr_ptr_q`=0.
- Outputs while reset is asserted: every valid and ready output is 0, and all bits outputs are 0.
- A path has zero added latency in IDLE and HOLD: bridge ready reaches the winner's ready in the same cycle.
- D path has zero added latency: bridge D passes straight to the granted requester combinationally.
- Best case with the bridge's 1-cycle response:
  - cycle 0: A handshake;
  - cycle 1: D handshake;
  - cycle 2: next A accepted.
  - Peak throughput: 1 transaction per 2 cycles.
- Simultaneous requests: one grant per transaction. A requester that keeps requesting waits at most `NUM_REQ`−1 transactions.
- A new request arriving in the same cycle as a D handshake is arbitrated in the following cycle, using the updated pointer.
- Reset asserted mid-transaction: return to IDLE immediately. The in-flight response is discarded; the bridge shares the same reset.

## Structure
- Types come from `tl_pkg` (`A_chan_bits_t`, `D_chan_bits_t`). The state enum stays local to the module.
- Sub-module `rr_arb_sel`: a purely combinational priority-rotate selector with parameter N.
  - Inputs: request vector and pointer.
  - Outputs: winner index and any-valid flag.

## Test plan
- Single requester 2 issues a Get to 0x1000 → A forwarded in the same cycle. The D response reaches only requester 2, and `rr_ptr`=3 afterwards.
- All 4 requesters valid continuously, bridge always ready, D ready always → grants in order 0,1,2,3,0. Exactly one D per grant, and each D carries that requester's source.
- Bridge holds A ready low for 5 cycles while requester 1 wins and requester 0 raises valid in cycle 2 → `TL_A_bits_o` stays requester 1's beat until accepted, then requester 0 is granted next.
- Requester 3 holds D ready low for 4 cycles → `TL_D_ready_o` stays 0, no new A is accepted, and completion occurs on cycle 5.
- Reset asserted in WAIT_D → all outputs 0 in the same cycle. After release, state is IDLE, `rr_ptr`=0, and requester 0 wins a 4-way contention.
- `NUM_REQ`=1 build with back-to-back PutFullData then Get → an AccessAck, then an AccessAckData, each delivered in the cycle after its A handshake.
